// File: rtl/ds_se_receiver_pkg.sv
// Shared DS link definitions, also used by the transmitter side.
package ds_se_receiver_pkg;

  localparam int DS_SYNC_STAGES_DEFAULT = 2;

  // Two recovered bits: [0] earlier, [1] later.
  typedef logic [1:0] dibit_t;

endpackage

// File: rtl/ds_sync_bit.sv
// N-stage resettable synchroniser for one asynchronous input.
module ds_sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [N-1:0] q;

  // Shift the raw input through the chain; the last stage is safe to use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= {q[N-2:0], din};
  end

  assign dout = q[N-1];

endmodule

// File: rtl/ds_se_receiver.sv
// Single-ended DS receiver front end: synchronise d/s, recover one bit per
// line transition and emit aligned bit pairs with parity.
module ds_se_receiver
  import ds_se_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = DS_SYNC_STAGES_DEFAULT
) (
  input  logic       rxClk,
  input  logic       rxReset_n,
  input  logic       d,
  input  logic       s,
  output logic [1:0] dq,
  output logic       dqValid,
  output logic       dqParity
);

  logic   ds_s, ss_s;
  logic   ph, phq, evt;
  logic   h, first;
  dibit_t dq_r;

  ds_sync_bit #(.N(SYNC_STAGES)) u_sync_d (
    .clk(rxClk), .rst_n(rxReset_n), .din(d), .dout(ds_s)
  );

  ds_sync_bit #(.N(SYNC_STAGES)) u_sync_s (
    .clk(rxClk), .rst_n(rxReset_n), .din(s), .dout(ss_s)
  );

  // A phase flip marks one bit; a simultaneous d/s change keeps the phase
  // and is therefore silently dropped.
  assign ph  = ds_s ^ ss_s;
  assign evt = ph ^ phq;

  // Phase tracking and pair assembly; alignment comes only from reset.
  always_ff @(posedge rxClk or negedge rxReset_n) begin
    if (!rxReset_n) begin
      phq      <= 1'b0;
      h        <= 1'b0;
      first    <= 1'b0;
      dq_r     <= 2'b00;
      dqValid  <= 1'b0;
      dqParity <= 1'b0;
    end else begin
      phq     <= ph;
      dqValid <= 1'b0;
      if (evt) begin
        if (!h) begin
          first <= ds_s;
          h     <= 1'b1;
        end else begin
          dq_r     <= {ds_s, first};
          dqParity <= ds_s ^ first;
          dqValid  <= 1'b1;
          h        <= 1'b0;
        end
      end
    end
  end

  assign dq = dq_r;

endmodule

// File: tb/tb_ds_se_receiver.sv
// Directed bench for ds_se_receiver with a queue-based scoreboard.
module tb_ds_se_receiver;

  logic       rxClk = 1'b0;
  logic       rxReset_n = 1'b0;
  logic       d = 1'b0, s = 1'b0;
  logic [1:0] dq;
  logic       dqValid, dqParity;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];   // {dq, parity}

  ds_se_receiver dut (
    .rxClk(rxClk), .rxReset_n(rxReset_n), .d(d), .s(s),
    .dq(dq), .dqValid(dqValid), .dqParity(dqParity)
  );

  always #10 rxClk = ~rxClk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive {d,s} and hold 30 ns; optionally record the pair it completes.
  task automatic step(input logic [1:0] v, input bit push, input logic [1:0] edq);
    {d, s} = v;
    if (push) exp_q.push_back({edq, edq[1] ^ edq[0]});
    #30;
  endtask

  // Monitor: every valid pulse must match the oldest expected pair.
  always @(negedge rxClk) begin
    if (rxReset_n && dqValid) begin
      logic [2:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: dq=%b par=%b with empty queue", dq, dqParity);
      end else begin
        e = exp_q.pop_front();
        if ({dq, dqParity} !== e) begin
          failures++;
          $display("FAIL pair: got dq=%b par=%b expected dq=%b par=%b",
                   dq, dqParity, e[2:1], e[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle.
    #30 rxReset_n = 1'b1;
    @(negedge rxClk);
    chk("rst_dq", {6'd0, dq}, 8'd0);
    chk("rst_valid", {7'd0, dqValid}, 8'd0);
    chk("rst_par", {7'd0, dqParity}, 8'd0);
    repeat (5) @(negedge rxClk);
    chk("idle_dq", {6'd0, dq}, 8'd0);
    chk("idle_valid", {7'd0, dqValid}, 8'd0);
    #5;

    // Basic stream once, then three repeats; alignment must not slip.
    for (int r = 0; r < 4; r++) begin
      step(2'b01, 0, 2'b00);
      step(2'b11, 1, 2'b10);
      step(2'b10, 0, 2'b00);
      step(2'b11, 1, 2'b11);
      step(2'b01, 0, 2'b00);
      step(2'b11, 1, 2'b10);
      step(2'b01, 0, 2'b00);
      step(2'b00, 1, 2'b00);
    end
    #100;
    chk("stream_drained", 8'(exp_q.size()), 8'd0);

    // Latency: drive away from edges, count edges from first sample of 11.
    @(negedge rxClk);
    {d, s} = 2'b01;
    repeat (4) @(negedge rxClk);
    {d, s} = 2'b11;
    exp_q.push_back({2'b10, 1'b1});
    @(posedge rxClk);            // edge 1 samples 11
    @(negedge rxClk);
    chk("lat_e1", {7'd0, dqValid}, 8'd0);
    @(posedge rxClk);
    @(negedge rxClk);
    chk("lat_e2", {7'd0, dqValid}, 8'd0);
    @(posedge rxClk);
    @(negedge rxClk);
    chk("lat_e3", {7'd0, dqValid}, 8'd1);
    @(negedge rxClk);
    chk("lat_width", {7'd0, dqValid}, 8'd0);
    #5;

    // Return to idle with a normal pair, then illegal 00->11 while h=0.
    step(2'b01, 0, 2'b00);
    step(2'b00, 1, 2'b00);
    step(2'b11, 0, 2'b00);       // illegal: dropped
    step(2'b10, 0, 2'b00);
    step(2'b00, 1, 2'b01);
    // Illegal change in the middle of a pair leaves h set.
    step(2'b01, 0, 2'b00);
    step(2'b10, 0, 2'b00);       // illegal: dropped
    step(2'b11, 1, 2'b10);
    #100;
    chk("illegal_drained", 8'(exp_q.size()), 8'd0);

    // Reset after the first bit of a pair (bit 1); it must be discarded.
    step(2'b10, 0, 2'b00);
    #40;
    rxReset_n = 1'b0;
    {d, s} = 2'b00;
    #40;
    chk("mid_rst_dq", {6'd0, dq}, 8'd0);
    chk("mid_rst_valid", {7'd0, dqValid}, 8'd0);
    rxReset_n = 1'b1;
    #65;
    step(2'b01, 0, 2'b00);
    step(2'b11, 1, 2'b10);
    #100;
    chk("final_drained", 8'(exp_q.size()), 8'd0);
    chk("final_dq", {6'd0, dq}, 8'h02);
    chk("final_par", {7'd0, dqParity}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
